cam_sensor_emulator: RTL and testbench

CAM_SENSOR_EMULATOR -- requirements
Module: cam_sensor_emulator

---
 rtl/cam_pkg.sv | 28 ++
 rtl/cam_pattern_gen.sv | 34 +++
 rtl/cam_sensor_emulator.sv | 181 ++++++++++++++++++
 tb/tb_cam_sensor_emulator.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types and constants for the camera sensor emulator.
package cam_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FV_SETUP,
    S_LINE_ACTIVE,
    S_LINE_BLANK,
    S_FV_HOLD,
    S_FRAME_BLANK
  } state_e;

  localparam logic [1:0] PAT_HRAMP = 2'd0;
  localparam logic [1:0] PAT_VRAMP = 2'd1;
  localparam logic [1:0] PAT_BARS  = 2'd2;
  localparam logic [1:0] PAT_MOVE  = 2'd3;

  localparam int FC_W = 8;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cam_pattern_gen.sv
// Combinational test-pattern pixel generator.
module cam_pattern_gen
  import cam_pkg::*;
#(
  parameter int W  = 10,
  parameter int XW = 10,
  parameter int YW = 9
) (
  input  logic [XW-1:0]   x_i,
  input  logic [YW-1:0]   y_i,
  input  logic [2:0]      bar_i,
  input  logic [FC_W-1:0] fc_i,
  input  logic [1:0]      pat_i,
  output logic [W-1:0]    pix_o
);

  logic [W-1:0] bars;

  always_comb begin
    bars = '0;
    // bar index repeated MSB-first across the word
    for (int i = 0; i < W; i++) begin
      bars[W-1-i] = bar_i[2-(i%3)];
    end
    pix_o = '0;
    unique case (pat_i)
      PAT_HRAMP: pix_o = W'(x_i);
      PAT_VRAMP: pix_o = W'(y_i);
      PAT_BARS:  pix_o = bars;
      PAT_MOVE:  pix_o = W'(x_i) + W'(fc_i);
    endcase
  end

endmodule

// File: rtl/cam_sensor_emulator.sv
// Parallel camera sensor emulator: FV/LV timing plus test patterns.
module cam_sensor_emulator
  import cam_pkg::*;
#(
  parameter int C_PIXEL_WIDTH = 10,
  parameter int C_H_ACTIVE    = 640,
  parameter int C_H_BLANK     = 32,
  parameter int C_V_ACTIVE    = 480,
  parameter int C_FV_SETUP    = 4,
  parameter int C_FV_HOLD     = 4,
  parameter int C_V_BLANK     = 100
) (
  input  logic                     pclk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [1:0]               pattern_sel,
  output logic [C_PIXEL_WIDTH-1:0] pixel_out,
  output logic                     line_valid_out,
  output logic                     frame_valid_out,
  output logic                     frame_done
);

  localparam int XW = cnt_w(C_H_ACTIVE);
  localparam int YW = cnt_w(C_V_ACTIVE);
  localparam int CW = cnt_w(max2(max2(C_H_BLANK, C_V_BLANK),
                                 max2(C_FV_SETUP, C_FV_HOLD)));

  localparam logic [XW-1:0] X_LAST     = XW'(C_H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(C_V_ACTIVE - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(C_FV_SETUP - 1);
  localparam logic [CW-1:0] HB_LAST    = CW'(C_H_BLANK - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(C_FV_HOLD - 1);
  localparam logic [CW-1:0] VB_LAST    = CW'(C_V_BLANK - 1);

  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [XW-1:0]            x_q, x_d;
  logic [YW-1:0]            y_q, y_d;
  logic [2:0]               bar_q, bar_d;
  logic [XW-1:0]            acc_q, acc_d;
  logic [FC_W-1:0]          fc_q, fc_d;
  logic [1:0]               pat_q, pat_d;
  logic [2:0]               bar_nx;
  logic [XW-1:0]            acc_nx;
  logic [C_PIXEL_WIDTH-1:0] pix_nx;
  logic [C_PIXEL_WIDTH-1:0] pix_q;
  logic                     lv_q, fv_q, done_q;

  // acc tracks x*8 mod H, bar tracks x*8 div H
  always_comb begin
    acc_nx = acc_q;
    bar_nx = bar_q;
    for (int k = 0; k < 8; k++) begin
      if (acc_nx == X_LAST) begin
        acc_nx = '0;
        bar_nx = bar_nx + 3'd1;
      end else begin
        acc_nx = acc_nx + XW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    x_d     = x_q;
    y_d     = y_q;
    bar_d   = bar_q;
    acc_d   = acc_q;
    fc_d    = fc_q;
    pat_d   = pat_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (enable) begin
          state_d = S_FV_SETUP;
          pat_d   = pattern_sel;
        end
      end
      S_FV_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = S_LINE_ACTIVE;
          cnt_d   = '0;
          x_d     = '0;
          y_d     = '0;
          bar_d   = '0;
          acc_d   = '0;
        end
      end
      S_LINE_ACTIVE: begin
        cnt_d = '0;
        if (x_q == X_LAST) begin
          state_d = (y_q == Y_LAST) ? S_FV_HOLD : S_LINE_BLANK;
        end else begin
          x_d   = x_q + XW'(1);
          bar_d = bar_nx;
          acc_d = acc_nx;
        end
      end
      S_LINE_BLANK: begin
        if (cnt_q == HB_LAST) begin
          state_d = S_LINE_ACTIVE;
          cnt_d   = '0;
          x_d     = '0;
          y_d     = y_q + YW'(1);
          bar_d   = '0;
          acc_d   = '0;
        end
      end
      S_FV_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_FRAME_BLANK;
          cnt_d   = '0;
          fc_d    = fc_q + 8'd1;
        end
      end
      S_FRAME_BLANK: begin
        if (cnt_q == VB_LAST) begin
          cnt_d = '0;
          if (enable) begin
            state_d = S_FV_SETUP;
            pat_d   = pattern_sel;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  cam_pattern_gen #(
    .W  (C_PIXEL_WIDTH),
    .XW (XW),
    .YW (YW)
  ) u_pat (
    .x_i   (x_d),
    .y_i   (y_d),
    .bar_i (bar_d),
    .fc_i  (fc_d),
    .pat_i (pat_d),
    .pix_o (pix_nx)
  );

  // outputs are registered from next-state so they align with state_q
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      bar_q   <= '0;
      acc_q   <= '0;
      fc_q    <= '0;
      pat_q   <= PAT_HRAMP;
      pix_q   <= '0;
      lv_q    <= 1'b0;
      fv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      bar_q   <= bar_d;
      acc_q   <= acc_d;
      fc_q    <= fc_d;
      pat_q   <= pat_d;
      pix_q   <= (state_d == S_LINE_ACTIVE) ? pix_nx : '0;
      lv_q    <= (state_d == S_LINE_ACTIVE);
      fv_q    <= (state_d != S_IDLE) && (state_d != S_FRAME_BLANK);
      done_q  <= (state_q == S_FV_HOLD) && (state_d == S_FRAME_BLANK);
    end
  end

  assign pixel_out       = pix_q;
  assign line_valid_out  = lv_q;
  assign frame_valid_out = fv_q;
  assign frame_done      = done_q;

endmodule

// File: tb/tb_cam_sensor_emulator.sv
// Scoreboard bench for cam_sensor_emulator with small timing parameters.
module tb_cam_sensor_emulator;

  localparam int W  = 10;
  localparam int H  = 8;
  localparam int V  = 3;
  localparam int FV_LEN = 32;

  logic         pclk;
  logic         rst_n;
  logic         enable;
  logic [1:0]   pattern_sel;
  logic [W-1:0] pixel_out;
  logic         line_valid_out;
  logic         frame_valid_out;
  logic         frame_done;

  int n_cmp;
  int n_bad;

  int exp_pix[$];
  int exp_len[$];
  int exp_gap[$];

  int bars[8];

  cam_sensor_emulator #(
    .C_PIXEL_WIDTH (W),
    .C_H_ACTIVE    (H),
    .C_H_BLANK     (2),
    .C_V_ACTIVE    (V),
    .C_FV_SETUP    (2),
    .C_FV_HOLD     (2),
    .C_V_BLANK     (5)
  ) dut (
    .pclk            (pclk),
    .rst_n           (rst_n),
    .enable          (enable),
    .pattern_sel     (pattern_sel),
    .pixel_out       (pixel_out),
    .line_valid_out  (line_valid_out),
    .frame_valid_out (frame_valid_out),
    .frame_done      (frame_done)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t",
               nm, act, act, exp, exp, $time);
    end
  endtask

  function automatic int exp_px(input int pat, input int x,
                                input int y, input int fc);
    int r;
    r = 0;
    case (pat)
      0: r = x;
      1: r = y;
      2: r = bars[x * 8 / H];
      default: r = (x + fc) % 1024;
    endcase
    return r;
  endfunction

  task automatic push_frame(input int pat, input int fc);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        exp_pix.push_back(exp_px(pat, x, y, fc));
    exp_len.push_back(FV_LEN);
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (!frame_done && n < 400);
    if (!frame_done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: frame_done timeout got 0 want 1", nm);
    end
  endtask

  task automatic wait_fv(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (!frame_valid_out && n < 400);
    if (!frame_valid_out) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: fv timeout got 0 want 1", nm);
    end
  endtask

  task automatic pulse_reset();
    @(posedge pclk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge pclk);
    #2 rst_n = 1'b1;
  endtask

  task automatic check_idle(input string nm);
    int seen;
    seen = 0;
    repeat (20) begin
      @(negedge pclk);
      if (frame_valid_out) seen = 1;
    end
    chk(nm, seen, 0);
  endtask

  // monitor: pixel scoreboard, frame length, gap and frame_done checks
  initial begin : monitor
    bit prev_fv, fell_seen;
    int fv_len, low_len, e;
    prev_fv = 0; fell_seen = 0; fv_len = 0; low_len = 0;
    forever begin
      @(negedge pclk);
      if (!rst_n) begin
        prev_fv = 0; fell_seen = 0; fv_len = 0; low_len = 0;
      end else begin
        if (line_valid_out) begin
          chk("lv_implies_fv", int'(frame_valid_out), 1);
          if (exp_pix.size() == 0) begin
            chk("pix_unexpected", int'(pixel_out), -1);
          end else begin
            e = exp_pix.pop_front();
            chk("pix", int'(pixel_out), e);
          end
        end else begin
          chk("pix_zero_lv_low", int'(pixel_out), 0);
        end
        chk("frame_done", int'(frame_done),
            int'(prev_fv && !frame_valid_out));
        if (frame_valid_out) begin
          if (!prev_fv) begin
            if (fell_seen && exp_gap.size() > 0)
              chk("fv_gap", low_len, exp_gap.pop_front());
            fv_len = 1;
          end else begin
            fv_len++;
          end
        end else begin
          if (prev_fv) begin
            if (exp_len.size() == 0) chk("fv_len_unexpected", fv_len, -1);
            else chk("fv_len", fv_len, exp_len.pop_front());
            fell_seen = 1;
            low_len = 1;
          end else begin
            low_len++;
          end
        end
        prev_fv = frame_valid_out;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n, m;
    n_cmp = 0;
    n_bad = 0;
    bars = '{10'h000, 10'h092, 10'h124, 10'h1B6,
             10'h249, 10'h2DB, 10'h36D, 10'h3FF};
    rst_n = 1'b0;
    enable = 1'b0;
    pattern_sel = 2'd0;
    repeat (2) @(negedge pclk);
    chk("rst_pix", int'(pixel_out), 0);
    chk("rst_lv", int'(line_valid_out), 0);
    chk("rst_fv", int'(frame_valid_out), 0);
    chk("rst_done", int'(frame_done), 0);
    @(posedge pclk);
    #2 rst_n = 1'b1;

    // single H-ramp frame from a one-cycle enable pulse
    push_frame(0, 0);
    @(negedge pclk) enable = 1'b1;
    @(negedge pclk) enable = 1'b0;
    wait_done("A");
    check_idle("A_idle_fv");

    // colour bars
    pattern_sel = 2'd2;
    push_frame(2, 0);
    @(negedge pclk) enable = 1'b1;
    @(negedge pclk) enable = 1'b0;
    wait_done("B");
    repeat (10) @(negedge pclk);

    // moving ramp over three back-to-back frames from fresh reset
    pulse_reset();
    pattern_sel = 2'd3;
    push_frame(3, 0);
    push_frame(3, 1);
    push_frame(3, 2);
    exp_gap.push_back(5);
    exp_gap.push_back(5);
    @(negedge pclk) enable = 1'b1;
    wait_done("C0");
    wait_done("C1");
    wait_fv("C2");
    enable = 1'b0;
    wait_done("C2");
    repeat (10) @(negedge pclk);

    // pattern change mid-frame, then enable drop mid third line
    pattern_sel = 2'd0;
    push_frame(0, 0);
    push_frame(1, 0);
    @(negedge pclk) enable = 1'b1;
    wait_fv("E0");
    @(negedge pclk);
    exp_gap.push_back(5);
    repeat (11) @(negedge pclk);
    pattern_sel = 2'd1;
    wait_done("E0");
    wait_fv("E1");
    repeat (25) @(negedge pclk);
    enable = 1'b0;
    wait_done("E1");
    check_idle("E_idle_fv");

    // reset in the middle of an active line
    pattern_sel = 2'd0;
    push_frame(0, 0);
    @(negedge pclk) enable = 1'b1;
    wait_fv("F0");
    repeat (4) @(negedge pclk);
    chk("F_lv_before_rst", int'(line_valid_out), 1);
    @(posedge pclk);
    #2 rst_n = 1'b0;
    #1;
    chk("F_rst_fv", int'(frame_valid_out), 0);
    chk("F_rst_lv", int'(line_valid_out), 0);
    chk("F_rst_pix", int'(pixel_out), 0);
    exp_pix.delete();
    exp_len.delete();
    push_frame(0, 0);
    repeat (2) @(posedge pclk);
    #2 rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (!frame_valid_out && n < 10);
    chk("F_fv_rise_cycles", n, 2);
    m = 0;
    do begin
      @(negedge pclk);
      m++;
    end while (!line_valid_out && m < 10);
    chk("F_lv_after_fv", m, 2);
    enable = 1'b0;
    wait_done("F1");
    repeat (10) @(negedge pclk);

    chk("sb_pix_left", exp_pix.size(), 0);
    chk("sb_len_left", exp_len.size(), 0);
    chk("sb_gap_left", exp_gap.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
